// File: rtl/icache_rv32_pkg.sv
// icache_rv32 shared definitions.
// Controller states, default geometry and address-field layout.
package icache_rv32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;

  // Byte offset inside a 32-bit word, never used for lookup.
  localparam int BYTE_W = 2;

  // Field layout for the default geometry.
  localparam int DEF_OFF_W   = $clog2(DEF_WORDS);
  localparam int DEF_IDX_W   = $clog2(DEF_LINES);
  localparam int DEF_OFF_LSB = BYTE_W;
  localparam int DEF_IDX_LSB = DEF_OFF_LSB + DEF_OFF_W;
  localparam int DEF_TAG_LSB = DEF_IDX_LSB + DEF_IDX_W;
  localparam int DEF_TAG_W   = 32 - DEF_TAG_LSB;

endpackage

// File: rtl/icache_rv32_refill.sv
// icache_rv32 line refill engine.
// Walks words 0..WORDS-1 with a one-cycle request gap between words.
module icache_rv32_refill
  import icache_rv32_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int OFF_W = DEF_OFF_W,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             start_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             iMemACK,
  output logic             oMemREQ,
  output logic [31:0]      oMemADDR,
  output logic             wr_o,
  output logic             last_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [OFF_W-1:0] cnt_o
);

  logic             active_q, active_d;
  logic             req_q, req_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // An ACK only counts while a request is actually out.
  assign wr_o     = req_q & iMemACK;
  assign last_o   = wr_o & (cnt_q == {OFF_W{1'b1}});
  assign oMemREQ  = req_q;
  assign oMemADDR = {tag_q, idx_q, cnt_q, 2'b00};
  assign tag_o    = tag_q;
  assign idx_o    = idx_q;
  assign cnt_o    = cnt_q;

  // Next state: latch on start, advance on ACK, re-request after the gap.
  always_comb begin
    active_d = active_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    idx_d    = idx_q;
    if (start_i) begin
      active_d = 1'b1;
      req_d    = 1'b1;
      cnt_d    = '0;
      tag_d    = tag_i;
      idx_d    = idx_i;
    end else if (wr_o) begin
      req_d = 1'b0;
      cnt_d = OFF_W'(cnt_q + 1'b1);
      if (last_o) begin
        active_d = 1'b0;
      end
    end else if (active_q) begin
      req_d = 1'b1;
    end
  end

  // Refill registers; reset drops any outstanding request.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      active_q <= 1'b0;
      req_q    <= 1'b0;
      cnt_q    <= '0;
      tag_q    <= '0;
      idx_q    <= '0;
    end else begin
      active_q <= active_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: rtl/icache_rv32.sv
// icache_rv32: direct-mapped RV32 instruction cache.
// Zero-latency hit path, word-by-word refill, fence.i flush.
module icache_rv32
  import icache_rv32_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iPCADDR,
  output logic [31:0] oINSTR,
  output logic        oStallI,
  input  logic        iFlush,
  output logic        oMemREQ,
  output logic [31:0] oMemADDR,
  input  logic        iMemACK,
  input  logic [31:0] iMemDATA
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = 32 - BYTE_W - OFF_W - IDX_W;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [1:0]       unused_pc;

  assign pc_off    = iPCADDR[BYTE_W +: OFF_W];
  assign pc_idx    = iPCADDR[BYTE_W+OFF_W +: IDX_W];
  assign pc_tag    = iPCADDR[31 -: TAG_W];
  assign unused_pc = iPCADDR[1:0];

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  state_e state_q, state_d;
  logic   flush_pend_q, flush_pend_d;

  logic             hit;
  logic             start;
  logic             clr_all;
  logic             set_line;
  logic             rf_wr;
  logic             rf_last;
  logic [TAG_W-1:0] rf_tag;
  logic [IDX_W-1:0] rf_idx;
  logic [OFF_W-1:0] rf_cnt;

  assign hit    = valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);
  assign oINSTR = data_q[pc_idx][pc_off];

  icache_rv32_refill #(
    .IDX_W(IDX_W),
    .OFF_W(OFF_W),
    .TAG_W(TAG_W)
  ) u_refill (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .start_i (start),
    .tag_i   (pc_tag),
    .idx_i   (pc_idx),
    .iMemACK (iMemACK),
    .oMemREQ (oMemREQ),
    .oMemADDR(oMemADDR),
    .wr_o    (rf_wr),
    .last_o  (rf_last),
    .tag_o   (rf_tag),
    .idx_o   (rf_idx),
    .cnt_o   (rf_cnt)
  );

  // Controller state and the flush seen during a refill.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= ST_IDLE;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next state: miss starts a refill, a late flush detours via FLUSH.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!iFlush && !hit) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        flush_pend_d = (flush_pend_q | iFlush) & ~rf_last;
        if (rf_last) begin
          state_d = (flush_pend_q | iFlush) ? ST_FLUSH : ST_IDLE;
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: stall unless an idle hit, refill start, valid updates.
  always_comb begin
    oStallI  = 1'b1;
    start    = 1'b0;
    clr_all  = 1'b0;
    set_line = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        oStallI = iFlush | ~hit;
        start   = ~iFlush & ~hit;
        clr_all = iFlush;
      end
      ST_REFILL: set_line = rf_last & ~(flush_pend_q | iFlush);
      ST_FLUSH:  clr_all  = 1'b1;
      default:   clr_all  = 1'b0;
    endcase
  end

  // Valid bits: cleared by reset or flush, set on a clean refill.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      valid_q <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
    end else if (set_line) begin
      valid_q[rf_idx] <= 1'b1;
    end
  end

  // Tag and data storage, written only by the refill engine.
  always_ff @(posedge iCLK) begin
    if (rf_wr) begin
      data_q[rf_idx][rf_cnt] <= iMemDATA;
    end
    if (rf_last) begin
      tag_q[rf_idx] <= rf_tag;
    end
  end

endmodule

// File: doc/icache_rv32.md
ICACHE_RV32 -- requirements
Module: icache_rv32

Interface
REQ-001 Parameter LINES, default 16: number of direct-mapped lines, power of two.
REQ-002 Parameter WORDS, default 4: 32-bit words per line, power of two.
REQ-003 iCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 iRST  input  1  reset, asynchronous, active-high.
REQ-005 iPCADDR  input  32  fetch address from core fetch stage.
REQ-006 oINSTR  output  32  instruction word for iPCADDR; valid when oStallI low.
REQ-007 oStallI  output  1  high = instruction not yet available; core holds iPCADDR.
REQ-008 iFlush  input  1  invalidate all lines (fence.i).
REQ-009 oMemREQ  output  1  backing-memory word read request.
REQ-010 oMemADDR  output  32  word-aligned backing-memory address.
REQ-011 iMemACK  input  1  backing memory returns iMemDATA this cycle.
REQ-012 iMemDATA  input  32  word read from backing memory.

Function
REQ-013 Address split with defaults: bits[1:0] ignored; word offset [3:2]; index [7:4]; tag [31:8]. Widths scale with LINES and WORDS.
REQ-014 Storage: per line one valid bit, one tag, WORDS data words, all in flops.
REQ-015 States: IDLE, REFILL, FLUSH.
REQ-016 IDLE lookup is combinational. A hit (valid and tag match) drives oStallI=0 and oINSTR=data[index][offset] in the same cycle, with zero latency.
REQ-017 IDLE miss drives oStallI=1 in the same cycle. The next edge latches tag/index into the refill register, clears the word counter and enters REFILL.
REQ-018 REFILL holds oStallI=1. It drives oMemREQ=1 and oMemADDR={latched tag, latched index, counter, 2'b00}.
REQ-019 oMemREQ and oMemADDR stay stable until iMemACK. On an ACK edge, iMemDATA is written to data[index][counter] and the counter increments.
REQ-020 Words are fetched in order 0..WORDS-1; oMemREQ drops for exactly one cycle between words.
REQ-021 The ACK for word WORDS-1 sets valid[index] and writes tag[index]. The state then returns to IDLE, and the lookup hits on the following cycle.
REQ-022 A changed iPCADDR during REFILL is ignored; the refill completes for the latched address.
REQ-023 iMemACK while oMemREQ=0 is ignored.
REQ-024 iFlush in IDLE clears all valid bits on the next edge. oStallI=1 in the iFlush cycle.
REQ-025 iFlush during REFILL is recorded. The refill completes, but the line is not marked valid; the state goes to FLUSH, which clears all valid bits for one cycle and then returns to IDLE.
REQ-026 iFlush is also recorded on the cycle of the final refill ACK.
REQ-027 oINSTR is don't-care while oStallI=1.

Reset
REQ-028 iRST asserted: state=IDLE, all valid=0, counter=0, pending flush=0, oMemREQ=0, oMemADDR=0.
REQ-029 Tag and data arrays are not reset.
REQ-030 Reset mid-REFILL aborts the refill; no line becomes valid, and the outstanding request is dropped.
REQ-031 After reset the first fetch misses.

Structure
REQ-032 Shared package holds: the state enum, the default LINES and WORDS, and address-field width/offset constants.
REQ-033 One sub-module, icache_rv32_refill, contains the REFILL counter, request/ACK handshake and address generation; the tag/valid/data arrays stay in the top module.

Verification
REQ-034 Reset, fetch 0x00000100; memory ACKs after 2 cycles per word → oMemADDR sequence 0x100, 0x104, 0x108, 0x10C; then oStallI=0 with word0 data.
REQ-035 After REQ-034, fetch 0x104, 0x108, 0x10C → oStallI=0 every cycle, correct words, no oMemREQ.
REQ-036 Fetch 0x00001100 (same index, different tag) → miss and refill; then 0x100 misses again.
REQ-037 iFlush pulse during the third word of a refill of 0x200 → refill completes, FLUSH for 1 cycle, then 0x200 misses.
REQ-038 iRST asserted after the second ACK of a refill → oMemREQ=0 immediately; after release, the same address misses and refills from word 0.
REQ-039 Spurious iMemACK in IDLE plus iPCADDR change mid-refill → no array write; the refill targets the original line.
